// File: rtl/hs2way_fifo.sv
// hs2way_fifo: parametrised first-word-fall-through FIFO between two hs2way
// handshake channels. The input side accepts words when p_in_push & p_in_wait_n.
// The output side hands the head word off when p_out_push & p_out_wait_n.
// The fill level and almost-full flag are registered from the next-state level.
module hs2way_fifo #(
  parameter int unsigned g_data_size   = 8,
  parameter int unsigned g_depth_log2  = 4,
  parameter int unsigned g_afull_level = 12
) (
  input  logic                    p_clock,
  input  logic                    p_reset,
  input  logic                    p_flush,
  input  logic                    p_in_push,
  output logic                    p_in_wait_n,
  input  logic [g_data_size-1:0]  p_in_data,
  output logic                    p_out_push,
  input  logic                    p_out_wait_n,
  output logic [g_data_size-1:0]  p_out_data,
  output logic [g_depth_log2:0]   p_level,
  output logic                    p_afull
);

  localparam int unsigned c_ptr_w   = g_depth_log2;
  localparam int unsigned c_level_w = g_depth_log2 + 1;
  localparam int unsigned c_depth   = 1 << g_depth_log2;

  // Reject parameter combinations the design cannot honour
  if (g_depth_log2 < 1 || g_depth_log2 > 10) begin : g_bad_depth
    $error("hs2way_fifo: g_depth_log2 must be in 1..10");
  end
  if (g_afull_level < 1 || g_afull_level > c_depth) begin : g_bad_afull
    $error("hs2way_fifo: g_afull_level must be in 1..DEPTH");
  end

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state, state_next;
  logic [c_ptr_w-1:0]      wr_ptr, wr_ptr_next;
  logic [c_ptr_w-1:0]      rd_ptr, rd_ptr_next;
  logic [c_level_w-1:0]    level, level_next;
  logic                    in_wait_n_next;
  logic                    out_push_next;
  logic                    afull_next;
  logic                    wr;
  logic                    rd;
  logic                    mem_we;

  logic [g_data_size-1:0]  mem [c_depth];

  // Handshake qualification on both sides
  always_comb begin
    wr = p_in_push & p_in_wait_n;
    rd = p_out_push & p_out_wait_n;
  end

  // Next-state logic: flush wins over any transfer on the same edge
  always_comb begin
    state_next     = state;
    wr_ptr_next    = wr_ptr;
    rd_ptr_next    = rd_ptr;
    level_next     = level;
    mem_we         = 1'b0;
    in_wait_n_next = 1'b0;
    out_push_next  = 1'b0;
    afull_next     = 1'b0;

    if (p_flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = '0;
    end else begin
      if (wr) begin
        mem_we      = 1'b1;
        wr_ptr_next = wr_ptr + c_ptr_w'(1);
      end
      if (rd) begin
        rd_ptr_next = rd_ptr + c_ptr_w'(1);
      end
      level_next = level + c_level_w'(wr) - c_level_w'(rd);
    end

    case (state)
      ST_INIT: begin
        // Leaving init: storage is empty so the input side may open
        state_next     = ST_RUN;
        in_wait_n_next = 1'b1;
      end
      ST_RUN: begin
        in_wait_n_next = (level_next != c_level_w'(c_depth));
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase

    out_push_next = (level_next != '0);
    afull_next    = (level_next >= c_level_w'(g_afull_level));
  end

  // Control and status registers
  always_ff @(posedge p_clock or posedge p_reset) begin
    if (p_reset) begin
      state       <= ST_INIT;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      p_in_wait_n <= 1'b0;
      p_out_push  <= 1'b0;
      p_afull     <= 1'b0;
    end else begin
      state       <= state_next;
      wr_ptr      <= wr_ptr_next;
      rd_ptr      <= rd_ptr_next;
      level       <= level_next;
      p_in_wait_n <= in_wait_n_next;
      p_out_push  <= out_push_next;
      p_afull     <= afull_next;
    end
  end

  // Storage array, deliberately left without reset
  always_ff @(posedge p_clock) begin
    if (mem_we) begin
      mem[wr_ptr] <= p_in_data;
    end
  end

  // Head of the queue falls through to the output
  always_comb begin
    p_out_data = mem[rd_ptr];
    p_level    = level;
  end

endmodule
